// File: rtl/hotel_booking.sv
// hotel_booking: seven-room booking desk; a rising edge on register books a free room and bills the stay.
module hotel_booking (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  room_selection,
  input  logic        ac_selection,
  input  logic        wifi_selection,
  input  logic [2:0]  days,
  input  logic        register,
  output logic [15:0] bill,
  output logic [3:0]  room1,
  output logic [3:0]  room2,
  output logic [3:0]  room3_1,
  output logic [3:0]  room3_2,
  output logic [3:0]  room4_1,
  output logic [3:0]  room4_2,
  output logic [3:0]  room5,
  output logic [1:0]  ac_wifi
);
  logic        reg_d;
  logic [3:0]  st [1:7];
  logic [7:0]  occ;
  logic        acc, vip, dbl, incl, ac_g;
  logic [15:0] rate;
  always_comb begin
    occ = '0;
    for (int i = 1; i < 8; i++) occ[i] = st[i][3];
    vip  = room_selection == 3'd1 || room_selection == 3'd2;
    dbl  = room_selection == 3'd3 || room_selection == 3'd4;
    incl = room_selection == 3'd5 || room_selection == 3'd6;
    ac_g = incl | (~dbl & ac_selection);
    acc  = register & ~reg_d & (room_selection != 3'd0) & (days != 3'd0) & ~occ[room_selection];
    // AC is free in rooms where it is part of the package, so only charged elsewhere
    rate = (vip ? 16'd2000 : dbl ? 16'd800 : incl ? 16'd1200 : 16'd1000)
         + ((ac_g & ~incl) ? 16'd300 : 16'd0)
         + (wifi_selection ? 16'd100 : 16'd0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_d   <= 1'b0;
      bill    <= '0;
      ac_wifi <= '0;
      for (int i = 1; i < 8; i++) st[i] <= '0;
    end else begin
      reg_d <= register;
      if (acc) begin
        bill    <= rate * {13'd0, days};
        ac_wifi <= {ac_g, wifi_selection};
        for (int i = 1; i < 8; i++)
          if (room_selection == 3'(i)) st[i] <= {1'b1, days};
      end
    end
  end
  assign room1   = st[1];
  assign room2   = st[2];
  assign room3_1 = st[3];
  assign room3_2 = st[4];
  assign room4_1 = st[5];
  assign room4_2 = st[6];
  assign room5   = st[7];
endmodule

// File: tb/tb_hotel_booking.sv
// tb_hotel_booking: scoreboard bench; stimulus pushes model predictions, a monitor checks every cycle.
module tb_hotel_booking;
  logic        clk = 0, rst = 1;
  logic [2:0]  room_selection = 0, days = 0;
  logic        ac_selection = 0, wifi_selection = 0, register = 0;
  logic [15:0] bill;
  logic [3:0]  room1, room2, room3_1, room3_2, room4_1, room4_2, room5;
  logic [1:0]  ac_wifi;
  int errors = 0, checks = 0;

  hotel_booking dut (
    .clk(clk), .rst(rst), .room_selection(room_selection), .ac_selection(ac_selection),
    .wifi_selection(wifi_selection), .days(days), .register(register), .bill(bill),
    .room1(room1), .room2(room2), .room3_1(room3_1), .room3_2(room3_2),
    .room4_1(room4_1), .room4_2(room4_2), .room5(room5), .ac_wifi(ac_wifi)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bill;
    int aw;
    int room [1:7];
  } exp_t;
  exp_t q [$];

  int m_bill, m_aw, m_room [1:7];
  bit m_prev;
  int base_rate [8] = '{0, 2000, 2000, 800, 800, 1200, 1200, 1000};

  task automatic step(input bit r, input int sel, input bit ac, input bit wf, input int d, input bit rg);
    exp_t e;
    int ac_g, ac_chg;
    @(negedge clk);
    rst = r; room_selection = 3'(sel); ac_selection = ac; wifi_selection = wf;
    days = 3'(d); register = rg;
    if (r) begin
      m_bill = 0; m_aw = 0; m_prev = 0;
      for (int i = 1; i < 8; i++) m_room[i] = 0;
    end else begin
      if (rg && !m_prev && sel != 0 && d != 0 && m_room[sel] < 8) begin
        ac_g   = (sel == 3 || sel == 4) ? 0 : (sel == 5 || sel == 6) ? 1 : int'(ac);
        ac_chg = (sel == 1 || sel == 2 || sel == 7) && ac_g == 1 ? 300 : 0;
        m_bill = (base_rate[sel] + ac_chg + (wf ? 100 : 0)) * d;
        m_aw   = ac_g * 2 + int'(wf);
        m_room[sel] = 8 + d;
      end
      m_prev = rg;
    end
    e.bill = m_bill; e.aw = m_aw;
    for (int i = 1; i < 8; i++) e.room[i] = m_room[i];
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    int g [1:7];
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      g[1] = int'(room1); g[2] = int'(room2); g[3] = int'(room3_1); g[4] = int'(room3_2);
      g[5] = int'(room4_1); g[6] = int'(room4_2); g[7] = int'(room5);
      chk("bill", int'(bill), e.bill);
      chk("ac_wifi", int'(ac_wifi), e.aw);
      for (int i = 1; i < 8; i++) chk($sformatf("room_word%0d", i), g[i], e.room[i]);
    end
  end

  initial begin
    int n;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 3, 1); step(0, 1, 1, 0, 3, 0);
    step(0, 2, 0, 1, 2, 1); step(0, 2, 0, 1, 2, 0);
    step(0, 3, 0, 0, 1, 1); step(0, 3, 0, 0, 1, 0);
    step(0, 5, 1, 1, 4, 1); step(0, 5, 1, 1, 4, 0);
    step(0, 7, 1, 1, 5, 1); step(0, 7, 1, 1, 5, 0);
    step(0, 1, 0, 0, 2, 1); step(0, 1, 0, 0, 2, 0);
    step(0, 4, 1, 1, 0, 1); step(0, 4, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 4, 1, 1, 6, 1);
    step(0, 4, 1, 1, 6, 0);
    step(0, 6, 0, 0, 7, 0);
    step(1, 6, 1, 1, 7, 1);
    step(0, 6, 1, 1, 7, 1);
    step(0, 6, 1, 1, 7, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 59);
      step(n == 0, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 1));
    end
    n = 0;
    while (q.size() > 0 && n < 10) begin @(posedge clk); n++; end
    #2;
    if (q.size() > 0) chk("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hotel_booking.md
HOTEL_BOOKING -- requirements
Module: hotel_booking

Interface
REQ-001 The block SHALL have these ports (clock and reset first):
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- room_selection  input  3  room code: 1=room1 (VIP), 2=room2 (VIP), 3=room3_1 (double non-AC), 4=room3_2 (double non-AC), 5=room4_1 (double AC), 6=room4_2 (double AC), 7=room5 (PWD special), 0=none.
- ac_selection  input  1  AC requested.
- wifi_selection  input  1  Wi-Fi requested.
- days  input  3  stay length, 1-7 days.
- register  input  1  booking confirm button, level signal.
- bill  output  16  total bill of the last accepted booking, unsigned.
- room1, room2, room3_1, room3_2, room4_1, room4_2, room5  output  4 each  room status word.
- ac_wifi  output  2  {ac, wifi} granted to the last accepted booking.

REQ-002 All outputs SHALL be registered.

Function
REQ-003 The block SHALL register register into reg_d each clock; a booking request SHALL be register=1 with reg_d=0 (rising edge).
- Holding register high for many cycles yields one request only.
REQ-004 A request SHALL be accepted only if all of these hold:
- room_selection is not 0;
- days is not 0;
- the selected room's occupied bit is 0.
REQ-005 Acceptance SHALL occur on the same clock edge that detects the request; outputs show the result after that edge (1-cycle latency).
REQ-006 On acceptance, the selected room's status word SHALL be loaded with bit3=1 (occupied) and bits[2:0]=days. All other rooms SHALL be unchanged.
REQ-007 Per-day base rates SHALL be:
- room1/room2: 2000;
- room3_1/room3_2: 800;
- room4_1/room4_2: 1200;
- room5: 1000.
REQ-008 AC handling SHALL be:
- room3_1/room3_2: ac_selection ignored, granted ac=0, no charge.
- room4_1/room4_2: AC included, granted ac=1, no surcharge.
- other rooms: granted ac=ac_selection, surcharge 300/day when granted.
REQ-009 Wi-Fi SHALL be granted as wifi_selection for every room, with surcharge 100/day when granted.
REQ-010 On acceptance, bill SHALL be (base + AC surcharge + Wi-Fi surcharge) * days.
- Result is exact in 16 bits; maximum is 16800, so there is no overflow.
- ac_wifi SHALL load {granted ac, granted wifi}.
REQ-011 A rejected request or a non-request cycle SHALL leave bill, ac_wifi and all room words unchanged.
REQ-012 Rooms SHALL be released only by reset; rebooking an occupied room is rejected.
REQ-013 Input changes without a register rising edge SHALL have no effect.
REQ-014 The block SHALL contain no state beyond the seven room words, bill, ac_wifi and reg_d.

Reset
REQ-015 When rst=1 at a clock edge, the block SHALL clear:
- bill=0;
- ac_wifi=00;
- all seven room words=0000;
- reg_d=0.
REQ-016 Reset SHALL override any simultaneous request; no booking occurs in a reset cycle.
REQ-017 With register held high through reset release, the first cycle after reset SHALL detect a request (reg_d=0) and process it per REQ-004.
REQ-018 Reset in the middle of a sequence SHALL discard all bookings.

Verification
REQ-019 After reset: sel=1, ac=1, wifi=0, days=3, pulse register -> room1=1011, bill=6900, ac_wifi=10.
REQ-020 Then: sel=2, ac=0, wifi=1, days=2, pulse register -> room2=1010, bill=4200, ac_wifi=01; room1 still 1011.
REQ-021 Then: sel=3, ac=0, wifi=0, days=1 -> room3_1=1001, bill=800, ac_wifi=00.
REQ-022 Then: sel=5, ac=1, wifi=1, days=4 -> room4_1=1100, bill=5200, ac_wifi=11.
REQ-023 Then: sel=7, ac=1, wifi=1, days=5 -> room5=1101, bill=7000.
REQ-024 Rejection and edge checks:
- sel=1, days=2 (room1 occupied) -> bill stays 7000, room1 stays 1011.
- sel=4, days=0 -> no change.
- register held high 5 cycles on free room3_2 -> exactly one booking.
- rst=1 -> all outputs 0.
